// File: rtl/demo_sequencer.sv
// demo_sequencer: frame-paced animation sequencer (run/pause/single-step) driving frame_counter, scene, advance/scene pulses, frame-aligned pinout select and audio mute
module demo_sequencer #(
  parameter bit FULL_FPS   = 1'b1,
  parameter int FRAME_BITS = 12,
  parameter int SCENE_LEN  = 256,
  parameter int NUM_SCENES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  new_frame,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  pmod_sel,
  output logic [FRAME_BITS-1:0] frame_counter,
  output logic [2:0]            scene,
  output logic                  frame_advance,
  output logic                  scene_start,
  output logic                  pmod_sel_frame,
  output logic                  audio_mute
);
  localparam int SFW = $clog2(SCENE_LEN);
  typedef enum logic [1:0] {RUN, PAUSED, STEP} state_t;
  state_t state, state_n;
  logic step_d, half_phase, half_n, adv, fev, step_rise, last;
  logic [SFW-1:0] scene_frame;
  assign fev = new_frame & enable;
  assign step_rise = step & ~step_d;
  assign last = scene_frame == SFW'(SCENE_LEN - 1);
  always_comb begin
    state_n = state;
    half_n = half_phase;
    adv = 1'b0;
    case (state)
      RUN: if (fev) begin
        state_n = pause ? PAUSED : RUN;
        adv = !pause && (FULL_FPS || half_phase);
        half_n = (!pause && !FULL_FPS) ? ~half_phase : half_phase;
      end
      PAUSED: state_n = step_rise ? STEP : (fev && !pause) ? RUN : PAUSED;
      STEP: if (fev) begin
        adv = 1'b1;
        state_n = pause ? PAUSED : RUN;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      step_d <= 1'b1;
      half_phase <= 1'b0;
      frame_counter <= '0;
      scene <= '0;
      scene_frame <= '0;
      frame_advance <= 1'b0;
      scene_start <= 1'b0;
      pmod_sel_frame <= 1'b0;
      audio_mute <= 1'b0;
    end else begin
      state <= state_n;
      step_d <= step;
      half_phase <= half_n;
      frame_advance <= adv;
      scene_start <= adv && last;
      audio_mute <= state_n != RUN;
      if (fev) pmod_sel_frame <= pmod_sel;
      if (adv) begin
        frame_counter <= frame_counter + FRAME_BITS'(1);
        scene_frame <= last ? '0 : scene_frame + SFW'(1);
        if (last) scene <= (scene == 3'(NUM_SCENES - 1)) ? 3'd0 : scene + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_demo_sequencer.sv
// tb_demo_sequencer: scoreboard bench comparing two parameterisations against a behavioural model under directed and random stimulus
module tb_demo_sequencer;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, new_frame = 1'b0, pause = 1'b0, step = 1'b0, pmod_sel = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] fc0;
  logic [11:0] fc1;
  logic [2:0] sc0, sc1;
  logic fa0, fa1, ss0, ss1, ps0, ps1, am0, am1;
  demo_sequencer #(.FULL_FPS(1'b1), .FRAME_BITS(4), .SCENE_LEN(4), .NUM_SCENES(3)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame), .pause(pause), .step(step),
    .pmod_sel(pmod_sel), .frame_counter(fc0), .scene(sc0), .frame_advance(fa0), .scene_start(ss0),
    .pmod_sel_frame(ps0), .audio_mute(am0));
  demo_sequencer #(.FULL_FPS(1'b0), .FRAME_BITS(12), .SCENE_LEN(3), .NUM_SCENES(2)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame), .pause(pause), .step(step),
    .pmod_sel(pmod_sel), .frame_counter(fc1), .scene(sc1), .frame_advance(fa1), .scene_start(ss1),
    .pmod_sel_frame(ps1), .audio_mute(am1));
  typedef struct packed {logic adv, ss, psf, mute; logic [2:0] sc; logic [11:0] fc;} exp_t;
  typedef struct {int mode; bit hp; int fc; int sf; int sc; bit psf; bit mute; bit sd;} mdl_t;
  exp_t g[2];
  assign g[0] = {fa0, ss0, ps0, am0, sc0, 8'h00, fc0};
  assign g[1] = {fa1, ss1, ps1, am1, sc1, fc1};
  exp_t q_st[2][$];
  exp_t q_adv[2][$];
  mdl_t m[2];
  bit full[2] = '{1'b1, 1'b0};
  int fmod[2] = '{16, 4096};
  int slen[2] = '{4, 3};
  int nsc[2] = '{3, 2};
  int total = 0, bad = 0;
  // mode: 0 = running, 1 = paused, 2 = waiting for the frame that performs a single step
  task automatic model(input int i, input bit r, input bit fev, input bit p, input bit s, input bit ps);
    bit adv, sr;
    int nm;
    exp_t x;
    x = '0;
    adv = 1'b0;
    if (r) m[i] = '{0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    else begin
      sr = s && !m[i].sd;
      m[i].sd = s;
      nm = m[i].mode;
      if (m[i].mode == 0) begin
        if (fev && p) nm = 1;
        else if (fev) begin
          adv = full[i] || m[i].hp;
          if (!full[i]) m[i].hp = !m[i].hp;
        end
      end else if (m[i].mode == 1) begin
        if (sr) nm = 2;
        else if (fev && !p) nm = 0;
      end else if (fev) begin
        adv = 1'b1;
        nm = p ? 1 : 0;
      end
      if (adv) begin
        m[i].fc = (m[i].fc + 1) % fmod[i];
        if (m[i].sf == slen[i] - 1) begin
          m[i].sf = 0;
          m[i].sc = (m[i].sc + 1) % nsc[i];
          x.ss = 1'b1;
        end else m[i].sf++;
      end
      if (fev) m[i].psf = ps;
      m[i].mute = nm != 0;
      m[i].mode = nm;
    end
    x.adv = adv;
    x.psf = m[i].psf;
    x.mute = m[i].mute;
    x.sc = 3'(m[i].sc);
    x.fc = 12'(m[i].fc);
    q_st[i].push_back(x);
    if (adv) q_adv[i].push_back(x);
  endtask
  task automatic cyc(input bit r, input bit e, input bit nf, input bit p, input bit s, input bit ps);
    @(negedge clk);
    reset = r;
    enable = e;
    new_frame = nf;
    pause = p;
    step = s;
    pmod_sel = ps;
    for (int i = 0; i < 2; i++) model(i, r, e && nf, p, s, ps);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (q_st[i].size() != 0) begin
          e = q_st[i].pop_front();
          total++;
          if (g[i] !== e) begin
            bad++;
            $display("FAIL status dut%0d t=%0t got adv/ss/psf/mute=%b%b%b%b sc=%0d fc=%0d want %b%b%b%b sc=%0d fc=%0d",
              i, $time, g[i].adv, g[i].ss, g[i].psf, g[i].mute, g[i].sc, g[i].fc, e.adv, e.ss, e.psf, e.mute, e.sc, e.fc);
          end
          if (g[i].adv === 1'b1) begin
            total++;
            if (q_adv[i].size() == 0) begin
              bad++;
              $display("FAIL advance dut%0d t=%0t got unexpected advance fc=%0d want none", i, $time, g[i].fc);
            end else begin
              e = q_adv[i].pop_front();
              if ({g[i].sc, g[i].fc, g[i].ss} !== {e.sc, e.fc, e.ss}) begin
                bad++;
                $display("FAIL advance dut%0d t=%0t got sc=%0d fc=%0d ss=%b want sc=%0d fc=%0d ss=%b",
                  i, $time, g[i].sc, g[i].fc, g[i].ss, e.sc, e.fc, e.ss);
              end
            end
          end
        end
      end
    end
  end
  initial begin
    bit p, s, ps;
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 1);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    repeat (6) begin
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) begin
      cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    repeat (8) begin
      cyc(0, 1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
    end
    p = 0;
    s = 0;
    ps = 0;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) p = !p;
      if ($urandom_range(0, 5) == 0) s = !s;
      if ($urandom_range(0, 7) == 0) ps = !ps;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, p, s, ps);
    end
    cyc(0, 0, 0, p, s, ps);
    @(posedge clk);
    #3;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q_adv[i].size() != 0 || q_st[i].size() != 0) begin
        bad++;
        $display("FAIL drain dut%0d got pending adv=%0d st=%0d want 0", i, q_adv[i].size(), q_st[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
